fpu_mul_result_commit: RTL
==========================

// Module: fpu_mul_result_commit
// PURPOSE
//  Consumer of the multiplier exception flags. Takes the raw product (sign/Ez/Mz) plus the
//  invalid/overflow/underflow/zero flags, substitutes the IEEE-754 special value, and
//  registers the result through a 2-entry valid/ready skid buffer. Keeps sticky status bits
//  and a saturating exception-event counter. Sits between the multiplier datapath and the
//  FPU writeback port.
// PARAMETERS
//  QNAN_MANT  23'h400000  mantissa of the canonical quiet NaN (sign 0, exponent 8'hFF)
//  CNT_W      8           width of the exception-event counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      reset, asynchronous assert, active-low
//  in_valid     in   1      product and flags valid
//  in_ready     out  1      stage can accept (registered, = !full)
//  sign_i       in   1      product sign (Sx^Sy)
//  ez_i         in   8      raw product exponent
//  mz_i         in   23     raw product mantissa
//  invalid_i    in   1      invalid flag from the detector
//  overflow_i   in   1      overflow flag from the detector
//  underflow_i  in   1      underflow flag from the detector
//  zero_i       in   1      zero flag from the detector
//  out_valid    out  1      result valid
//  out_ready    in   1      writeback accepts
//  result_o     out  32     final IEEE single result
//  flags_o      out  4      {NV,OF,UF,ZR} for result_o
//  sticky_o     out  3      sticky {NV,OF,UF}
//  sticky_clr   in   1      one-cycle pulse, clears sticky_o
//  exc_cnt_o    out  CNT_W  count of committed results with NV|OF|UF set, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, except in_ready=1; buffer empty.
//  - Result select, priority high->low:
//    invalid -> {1'b0,8'hFF,QNAN_MANT}; overflow -> {sign,8'hFF,23'h0};
//    zero -> {sign,8'h00,23'h0}; underflow -> see CONFIGURATION; else {sign,ez_i,mz_i}.
//  - flags_o carries all four input flags unmodified, including lower-priority ones.
//  - Input accepted when in_valid&in_ready; output transferred when out_valid&out_ready.
//  - Latency: accepted op appears on out_valid the next cycle when the buffer is empty.
//  - Skid buffer: 2 entries, FIFO order. in_ready deasserts the cycle after the 2nd entry
//    fills. result_o/flags_o stay stable while out_valid&!out_ready.
//  - Simultaneous accept+transfer with 1 entry: occupancy stays 1, no bubble.
//  - Full with out_ready=1: in_ready is 0 that cycle and returns to 1 the next cycle.
//  - sticky_o |= {NV,OF,UF} of each transferred result.
//  - sticky_clr coinciding with a transfer: the cleared value is OR'ed with the new bits
//    (set wins).
//  - exc_cnt_o increments by 1 per transfer with any of NV/OF/UF set; holds at all-ones.
//    Cleared only by reset.
//  - rst_n low mid-operation: buffered ops are discarded at once; no partial transfer.
// CONFIGURATION
//  FPU_FLUSH_DENORM_EN defined: underflow result = {sign,8'h00,23'h0}; UF still reported.
//  Not defined: underflow result = {sign,8'h00,mz_i} (raw mantissa kept, exponent forced to 0).
// STRUCTURE
//  fpu_pkg:
//    - localparams FLAG_NV=3, FLAG_OF=2, FLAG_UF=1, FLAG_ZR=0
//    - EXP_MAX=8'hFF
//    - QNAN constant
//    - typedef struct fp32_t {sign, exp[7:0], mant[22:0]}
//  Sub-module fpu_skid_buf: generic 2-entry valid/ready buffer, width 36
//    (32 result + 4 flags). Special-value select stays combinational in the top module.
// TESTING
//  1. invalid_i=1, sign_i=1 -> result_o=32'h7FC00000, flags_o=4'b1000, sticky_o=3'b100,
//     exc_cnt_o=1.
//  2. overflow_i=1, sign_i=1 -> result_o=32'hFF800000; same op with zero_i=1 -> overflow wins.
//  3. underflow_i=1, mz_i=23'h000123, sign_i=0 -> 32'h00000000 with the macro,
//     32'h00000123 without.
//  4. out_ready=0, three back-to-back ops:
//     - in_ready falls after op 2; op 3 is held.
//     - out_ready=1: ops 1,2,3 emerge in order, each stable while stalled.
//  5. sticky_clr pulsed in the same cycle an OF result transfers -> sticky_o=3'b010;
//     sticky_clr alone -> 3'b000.
//  6. 260 invalid ops with CNT_W=8 -> exc_cnt_o saturates at 8'hFF.
//  7. Reset asserted with 2 ops buffered -> out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and types for the FP32 multiplier result-commit slice.
package fpu_pkg;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_ZR = 0;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = {1'b0, EXP_MAX, 23'h400000};

  // Committed entry: 32-bit result followed by the 4 flag bits
  localparam int ENTRY_W = 36;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

endpackage

// File: rtl/fpu_mul_result_commit_if.sv
// Product-in / result-out handshake bundle of the multiplier commit stage.
interface fpu_mul_result_commit_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_i;
  logic [7:0]  ez_i;
  logic [22:0] mz_i;
  logic        invalid_i;
  logic        overflow_i;
  logic        underflow_i;
  logic        zero_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_o;
  logic [3:0]  flags_o;

  modport master (
    output in_valid, sign_i, ez_i, mz_i, invalid_i, overflow_i, underflow_i, zero_i,
    output out_ready,
    input  in_ready, out_valid, result_o, flags_o
  );

  modport slave (
    input  in_valid, sign_i, ez_i, mz_i, invalid_i, overflow_i, underflow_i, zero_i,
    input  out_ready,
    output in_ready, out_valid, result_o, flags_o
  );
endinterface

// File: rtl/fpu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer, FIFO order, registered in_ready (= !full).
module fpu_skid_buf #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic         in_ready_reg;
  logic         push;
  logic         pop;

  assign push      = in_valid & in_ready_reg;
  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = in_ready_reg;
  // Head entry is a register, so the output holds still during a stall
  assign out_data  = mem_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 2'd1;
    else if (!push && pop)
      count_next = count_reg - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      in_ready_reg <= 1'b1;
    end else begin
      if (push)
        wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      count_reg    <= count_next;
      in_ready_reg <= (count_next != 2'd2);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        mem_reg[gi] <= '0;
      else if (push && (wr_ptr_reg == 1'(gi)))
        mem_reg[gi] <= in_data;
    end
  end

endmodule

// File: rtl/fpu_mul_result_commit.sv
// Substitutes IEEE-754 special values from multiplier flags, buffers results in a 2-entry
// skid buffer, tracks sticky status and a saturating exception counter.
// Optional FPU_FLUSH_DENORM_EN: underflowing results are flushed to signed zero.
module fpu_mul_result_commit
  import fpu_pkg::*;
#(
  parameter logic [22:0] QNAN_MANT = 23'h400000,
  parameter int          CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fpu_mul_result_commit_if.slave   bus,
  input  logic                     sticky_clr,
  output logic [2:0]               sticky_o,
  output logic [CNT_W-1:0]         exc_cnt_o
);

  fp32_t               res_sel;
  logic [3:0]          flags_in;
  logic [ENTRY_W-1:0]  buf_out;
  logic                buf_in_ready;
  logic                buf_out_valid;
  logic                xfer;
  logic [2:0]          xfer_exc;
  logic [2:0]          sticky_reg;
  logic [CNT_W-1:0]    cnt_reg;

  always_comb begin
    flags_in          = '0;
    flags_in[FLAG_NV] = bus.invalid_i;
    flags_in[FLAG_OF] = bus.overflow_i;
    flags_in[FLAG_UF] = bus.underflow_i;
    flags_in[FLAG_ZR] = bus.zero_i;
  end

  always_comb begin
    res_sel = fp32_t'({bus.sign_i, bus.ez_i, bus.mz_i});
    if (bus.invalid_i)
      res_sel = fp32_t'({QNAN[31:23], QNAN_MANT});
    else if (bus.overflow_i)
      res_sel = fp32_t'({bus.sign_i, EXP_MAX, 23'h0});
    else if (bus.zero_i)
      res_sel = fp32_t'({bus.sign_i, 8'h00, 23'h0});
    else if (bus.underflow_i) begin
`ifdef FPU_FLUSH_DENORM_EN
      res_sel = fp32_t'({bus.sign_i, 8'h00, 23'h0});
`else
      res_sel = fp32_t'({bus.sign_i, 8'h00, bus.mz_i});
`endif
    end
  end

  fpu_skid_buf #(.W(ENTRY_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (buf_in_ready),
    .in_data   ({res_sel, flags_in}),
    .out_valid (buf_out_valid),
    .out_ready (bus.out_ready),
    .out_data  (buf_out)
  );

  assign bus.in_ready  = buf_in_ready;
  assign bus.out_valid = buf_out_valid;
  assign bus.result_o  = buf_out[ENTRY_W-1:4];
  assign bus.flags_o   = buf_out[3:0];

  assign xfer     = buf_out_valid & bus.out_ready;
  assign xfer_exc = xfer ? {buf_out[FLAG_NV], buf_out[FLAG_OF], buf_out[FLAG_UF]} : 3'b000;

  // Clear first, then OR in the transferring bits so a coincident set survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_reg <= 3'b000;
    else
      sticky_reg <= (sticky_clr ? 3'b000 : sticky_reg) | xfer_exc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if ((|xfer_exc) && (cnt_reg != {CNT_W{1'b1}}))
      cnt_reg <= cnt_reg + CNT_W'(1);
  end

  assign sticky_o  = sticky_reg;
  assign exc_cnt_o = cnt_reg;

endmodule
